// File: rtl/fm_wave_pkg.sv
// ============================================================================
// Module : fm_wave_pkg
// Brief  : Shared types, wave codes, width defaults and the octave priority
//          encoder for the wavetable voice reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fm_wave_pkg;

    localparam int c_DWIDTH = 16;
    localparam int c_AWIDTH = 12;
    localparam int c_FRACW  = 12;

    localparam logic [1:0] c_WAVE_SINE   = 2'b00;
    localparam logic [1:0] c_WAVE_SAW    = 2'b01;
    localparam logic [1:0] c_WAVE_TRI    = 2'b10;
    localparam logic [1:0] c_WAVE_SQUARE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_LERP = 3'd4,
        S_MIX  = 3'd5
    } state_t;

    // Index of the highest set bit; 0 for a zero word (caller checks for zero).
    function automatic logic [4:0] msb_index(input logic [31:0] v);
        msb_index = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) msb_index = 5'(i);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/wave_lerp.sv
// ============================================================================
// Module : wave_lerp
// Brief  : Combinational linear interpolation y = a + ((b-a)*w >>> WW).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wave_lerp #(
    parameter int DWIDTH = 16,
    parameter int WW     = 12
) (
    input  logic signed [DWIDTH-1:0] i_a,
    input  logic signed [DWIDTH-1:0] i_b,
    input  logic        [WW-1:0]     i_weight,
    output logic signed [DWIDTH-1:0] o_y
);

    localparam int c_PW = DWIDTH + 1 + WW;

    logic signed [DWIDTH:0]   w_diff;
    logic signed [c_PW-1:0]   w_diffX;
    logic signed [c_PW-1:0]   w_weightX;
    logic signed [c_PW-1:0]   w_prod;
    logic signed [c_PW-1:0]   w_aX;

    assign w_diff    = $signed({i_b[DWIDTH-1], i_b}) - $signed({i_a[DWIDTH-1], i_a});
    assign w_diffX   = c_PW'(w_diff);
    assign w_weightX = $signed({{(DWIDTH + 1){1'b0}}, i_weight});
    assign w_prod    = w_diffX * w_weightX;
    assign w_aX      = c_PW'(i_a);

    // Arithmetic shift floors toward -inf; the sum always lands inside DWIDTH.
    assign o_y = DWIDTH'(w_aX + (w_prod >>> WW));

endmodule

`default_nettype wire

// File: rtl/wavetable_voice_reader.sv
// ============================================================================
// Module : wavetable_voice_reader
// Brief  : Per-voice wavetable reader: phase accumulator, two-octave ROM
//          request, pairwise interpolation and octave crossfade.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wavetable_voice_reader
    import fm_wave_pkg::*;
#(
    parameter int DWIDTH   = c_DWIDTH,
    parameter int AWIDTH   = c_AWIDTH,
    parameter int FRACW    = c_FRACW,
    parameter int ROM_LAT  = 2,
    parameter int OCT_BASE = 16,
    parameter int MAX_OCT  = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  sample_tick,
    input  logic [31:0]           freq_word,
    input  logic [1:0]            wave,
    input  logic                  phase_rst,
    output logic                  rom_en,
    output logic [1:0]            rom_wave,
    output logic [2:0]            rom_octave,
    output logic [AWIDTH-1:0]     rom_addr,
    input  logic [2*DWIDTH-1:0]   rom_anti,
    input  logic [2*DWIDTH-1:0]   rom_interp,
    output logic [DWIDTH-1:0]     sample_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int c_CW = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;

    state_t                    r_state;
    state_t                    w_next;
    logic [31:0]               r_phase;
    logic [31:0]               r_freq;
    logic [31:0]               w_phaseEff;
    logic [FRACW-1:0]          r_frac;
    logic [7:0]                r_xfade;
    logic [AWIDTH-1:0]         r_romAddr;
    logic [1:0]                r_romWave;
    logic [2:0]                r_romOctave;
    logic [c_CW-1:0]           r_waitCnt;
    logic signed [DWIDTH-1:0]  r_a0, r_a1, r_i0, r_i1;
    logic signed [DWIDTH-1:0]  r_yA, r_yI;
    logic signed [DWIDTH-1:0]  w_yA, w_yI, w_mix;
    logic [DWIDTH-1:0]         r_sampleOut;
    logic                      r_sampleValid;
    logic                      r_overrun;
    logic                      r_rstPend;
    logic [4:0]                w_m;
    int                        w_octFull;
    logic [2:0]                w_octave;
    logic [7:0]                w_xfade;

    // Octave pick: highest set bit relative to OCT_BASE, crossfade from the 8 bits below it.
    always_comb begin
        w_m       = msb_index(freq_word);
        w_octFull = int'(w_m) - OCT_BASE + 1;
        w_octave  = '0;
        w_xfade   = '0;
        if (freq_word != '0 && w_octFull >= 1) begin
            if (w_octFull >= MAX_OCT) begin
                w_octave = 3'(MAX_OCT);
            end else begin
                w_octave = 3'(w_octFull);
                w_xfade  = 8'(freq_word >> (w_m - 5'd8));
            end
        end
    end

    assign w_phaseEff = phase_rst ? '0 : r_phase;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_tick) w_next = S_REQ;
            S_REQ:   w_next = (ROM_LAT > 1) ? S_WAIT : S_CAPT;
            S_WAIT:  if (int'(r_waitCnt) >= ROM_LAT - 2) w_next = S_CAPT;
            S_CAPT:  w_next = S_LERP;
            S_LERP:  w_next = S_MIX;
            S_MIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_phase       <= '0;
            r_freq        <= '0;
            r_frac        <= '0;
            r_xfade       <= '0;
            r_romAddr     <= '0;
            r_romWave     <= '0;
            r_romOctave   <= '0;
            r_waitCnt     <= '0;
            r_a0          <= '0;
            r_a1          <= '0;
            r_i0          <= '0;
            r_i1          <= '0;
            r_yA          <= '0;
            r_yI          <= '0;
            r_sampleOut   <= '0;
            r_sampleValid <= 1'b0;
            r_overrun     <= 1'b0;
            r_rstPend     <= 1'b0;
        end else begin
            r_sampleValid <= 1'b0;
            r_waitCnt     <= (r_state == S_WAIT) ? r_waitCnt + 1'b1 : '0;
            if (sample_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            // A note-on during a read is deferred to the MIX edge so the in-flight sample is untouched.
            if (phase_rst && r_state != S_IDLE && r_state != S_MIX) r_rstPend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (phase_rst) r_phase <= '0;
                    if (sample_tick) begin
                        r_freq      <= freq_word;
                        r_romWave   <= wave;
                        r_romAddr   <= w_phaseEff[31 -: AWIDTH];
                        r_frac      <= w_phaseEff[31-AWIDTH -: FRACW];
                        r_romOctave <= w_octave;
                        r_xfade     <= w_xfade;
                    end
                end
                S_CAPT: begin
                    r_a0 <= rom_anti[DWIDTH-1:0];
                    r_a1 <= rom_anti[2*DWIDTH-1:DWIDTH];
                    r_i0 <= rom_interp[DWIDTH-1:0];
                    r_i1 <= rom_interp[2*DWIDTH-1:DWIDTH];
                end
                S_LERP: begin
                    r_yA <= w_yA;
                    r_yI <= w_yI;
                end
                S_MIX: begin
                    r_sampleOut   <= w_mix;
                    r_sampleValid <= 1'b1;
                    r_phase       <= (r_rstPend || phase_rst) ? '0 : r_phase + r_freq;
                    r_rstPend     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    wave_lerp #(.DWIDTH(DWIDTH), .WW(FRACW)) u_lerpAnti (
        .i_a(r_a0), .i_b(r_a1), .i_weight(r_frac), .o_y(w_yA)
    );

    wave_lerp #(.DWIDTH(DWIDTH), .WW(FRACW)) u_lerpInterp (
        .i_a(r_i0), .i_b(r_i1), .i_weight(r_frac), .o_y(w_yI)
    );

    wave_lerp #(.DWIDTH(DWIDTH), .WW(8)) u_lerpMix (
        .i_a(r_yA), .i_b(r_yI), .i_weight(r_xfade), .o_y(w_mix)
    );

    assign rom_en       = (r_state == S_REQ);
    assign rom_wave     = r_romWave;
    assign rom_octave   = r_romOctave;
    assign rom_addr     = r_romAddr;
    assign sample_out   = r_sampleOut;
    assign sample_valid = r_sampleValid;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = r_overrun;

endmodule

`default_nettype wire
